// File: rtl/bicubic_phase_gen.sv
// Bicubic phase generator: walks a destination raster and emits, per sample,
// the clamped 4-tap source column window, fraction powers and source row.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle frame request (accepted only when idle)
//   src_w/src_h          source frame size in pixels
//   dst_w/dst_h          destination frame size in pixels
//   step_x/step_y        12.8 fixed-point source step per dst pixel / line
//   out_ready            downstream accepts the current sample
//   out_valid            sample fields below are valid
//   idx0..idx3           clamped source columns i-1, i, i+1, i+2
//   u, u_sq, u_cu        horizontal fraction and its exact square / cube
//   src_y, v             clamped source row and vertical fraction
//   line_last            sample closes its destination line
//   frame_done           pulse after the final sample is accepted
//   busy                 frame in progress (through frame_done)
module bicubic_phase_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] src_w,
  input  logic [11:0] src_h,
  input  logic [11:0] dst_w,
  input  logic [11:0] dst_h,
  input  logic [19:0] step_x,
  input  logic [19:0] step_y,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [11:0] idx0,
  output logic [11:0] idx1,
  output logic [11:0] idx2,
  output logic [11:0] idx3,
  output logic [7:0]  u,
  output logic [15:0] u_sq,
  output logic [23:0] u_cu,
  output logic [11:0] src_y,
  output logic [7:0]  v,
  output logic        line_last,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // latched frame configuration
  logic [11:0] sw_q, sh_q, dw_q, dh_q;
  logic [19:0] sx_q, sy_q;

  // issue (accumulate) state
  logic [19:0] pos_x_q, pos_x_d;
  logic [19:0] pos_y_q, pos_y_d;
  logic [11:0] x_cnt_q, x_cnt_d;
  logic [11:0] y_cnt_q, y_cnt_d;
  logic        issued_q, issued_d;

  // stage 1: accumulator snapshot
  logic        v1_q;
  logic [19:0] px1_q, py1_q;
  logic        ll1_q, fl1_q;

  // stage 2: clamped indices and square
  logic        v2_q;
  logic [11:0] i0_2q, i1_2q, i2_2q, i3_2q;
  logic [7:0]  u2_q;
  logic [15:0] usq2_q;
  logic [11:0] sy2_q;
  logic [7:0]  vv2_q;
  logic        ll2_q, fl2_q;

  // stage 3: cube, output register
  logic        v3_q;
  logic [11:0] i0_3q, i1_3q, i2_3q, i3_3q;
  logic [7:0]  u3_q;
  logic [15:0] usq3_q;
  logic [23:0] ucu3_q;
  logic [11:0] sy3_q;
  logic [7:0]  vv3_q;
  logic        ll3_q, fl3_q;

  logic adv, issue, take, x_end, y_end, accept_last;

  // whole pipeline moves together; a stall freezes every stage
  assign adv   = !v3_q || out_ready;
  assign take  = (state_q == S_IDLE) && start;
  assign issue = (state_q == S_RUN) && !issued_q && adv;
  assign x_end = x_cnt_q == (dw_q - 12'd1);
  assign y_end = y_cnt_q == (dh_q - 12'd1);
  assign accept_last = v3_q && out_ready && fl3_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dst_w == 12'd0 || dst_h == 12'd0) state_d = S_DONE;
          else state_d = S_RUN;
        end
      end
      S_RUN:   if (accept_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    x_cnt_d  = x_cnt_q;
    y_cnt_d  = y_cnt_q;
    issued_d = issued_q;
    if (take) begin
      pos_x_d  = '0;
      pos_y_d  = '0;
      x_cnt_d  = '0;
      y_cnt_d  = '0;
      issued_d = 1'b0;
    end else if (issue) begin
      if (x_end) begin
        x_cnt_d = '0;
        pos_x_d = '0;
        pos_y_d = pos_y_q + sy_q;
        y_cnt_d = y_cnt_q + 12'd1;
        if (y_end) issued_d = 1'b1;
      end else begin
        x_cnt_d = x_cnt_q + 12'd1;
        pos_x_d = pos_x_q + sx_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q     <= '0;
      sh_q     <= '0;
      dw_q     <= '0;
      dh_q     <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      issued_q <= 1'b0;
    end else begin
      if (take) begin
        sw_q <= src_w;
        sh_q <= src_h;
        dw_q <= dst_w;
        dh_q <= dst_h;
        sx_q <= step_x;
        sy_q <= step_y;
      end
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      issued_q <= issued_d;
    end
  end

  // stage 2 combinational clamp; +1/+2 done in 13 bits so i near 4095
  // cannot wrap back below the limit
  logic [11:0] ci, cim1, wmax, hmax, cyi;
  logic [12:0] cip1, cip2;
  logic [11:0] c_i0, c_i1, c_i2, c_i3, c_sy;
  logic [7:0]  c_u;
  logic [15:0] c_usq;

  always_comb begin
    ci    = px1_q[19:8];
    cyi   = py1_q[19:8];
    wmax  = sw_q - 12'd1;
    hmax  = sh_q - 12'd1;
    cim1  = (ci == 12'd0) ? 12'd0 : ci - 12'd1;
    cip1  = {1'b0, ci} + 13'd1;
    cip2  = {1'b0, ci} + 13'd2;
    c_i0  = (cim1 > wmax) ? wmax : cim1;
    c_i1  = (ci > wmax) ? wmax : ci;
    c_i2  = (cip1 > {1'b0, wmax}) ? wmax : cip1[11:0];
    c_i3  = (cip2 > {1'b0, wmax}) ? wmax : cip2[11:0];
    c_sy  = (cyi > hmax) ? hmax : cyi;
    c_u   = px1_q[7:0];
    c_usq = 16'(c_u) * 16'(c_u);
  end

  // data registers load only with a valid sample so idle outputs stay 0
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      px1_q  <= '0;
      py1_q  <= '0;
      ll1_q  <= 1'b0;
      fl1_q  <= 1'b0;
      v2_q   <= 1'b0;
      i0_2q  <= '0;
      i1_2q  <= '0;
      i2_2q  <= '0;
      i3_2q  <= '0;
      u2_q   <= '0;
      usq2_q <= '0;
      sy2_q  <= '0;
      vv2_q  <= '0;
      ll2_q  <= 1'b0;
      fl2_q  <= 1'b0;
      v3_q   <= 1'b0;
      i0_3q  <= '0;
      i1_3q  <= '0;
      i2_3q  <= '0;
      i3_3q  <= '0;
      u3_q   <= '0;
      usq3_q <= '0;
      ucu3_q <= '0;
      sy3_q  <= '0;
      vv3_q  <= '0;
      ll3_q  <= 1'b0;
      fl3_q  <= 1'b0;
    end else if (adv) begin
      v1_q <= issue;
      if (issue) begin
        px1_q <= pos_x_q;
        py1_q <= pos_y_q;
        ll1_q <= x_end;
        fl1_q <= x_end && y_end;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        i0_2q  <= c_i0;
        i1_2q  <= c_i1;
        i2_2q  <= c_i2;
        i3_2q  <= c_i3;
        u2_q   <= c_u;
        usq2_q <= c_usq;
        sy2_q  <= c_sy;
        vv2_q  <= py1_q[7:0];
        ll2_q  <= ll1_q;
        fl2_q  <= fl1_q;
      end
      v3_q <= v2_q;
      if (v2_q) begin
        i0_3q  <= i0_2q;
        i1_3q  <= i1_2q;
        i2_3q  <= i2_2q;
        i3_3q  <= i3_2q;
        u3_q   <= u2_q;
        usq3_q <= usq2_q;
        ucu3_q <= 24'(usq2_q) * 24'(u2_q);
        sy3_q  <= sy2_q;
        vv3_q  <= vv2_q;
        ll3_q  <= ll2_q;
        fl3_q  <= fl2_q;
      end
    end
  end

  assign out_valid  = v3_q;
  assign idx0       = i0_3q;
  assign idx1       = i1_3q;
  assign idx2       = i2_3q;
  assign idx3       = i3_3q;
  assign u          = u3_q;
  assign u_sq       = usq3_q;
  assign u_cu       = ucu3_q;
  assign src_y      = sy3_q;
  assign v          = vv3_q;
  assign line_last  = v3_q & ll3_q;
  assign frame_done = state_q == S_DONE;
  assign busy       = state_q != S_IDLE;

endmodule

// File: tb/tb_bicubic_phase_gen.sv
// Self-checking bench for bicubic_phase_gen: scoreboard of expected
// samples from a reference model, plus directed boundary checks.
module tb_bicubic_phase_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, out_ready;
  logic [11:0] src_w, src_h, dst_w, dst_h;
  logic [19:0] step_x, step_y;
  logic        out_valid, line_last, frame_done, busy;
  logic [11:0] idx0, idx1, idx2, idx3, src_y;
  logic [7:0]  u, v;
  logic [15:0] u_sq;
  logic [23:0] u_cu;

  bicubic_phase_gen dut (
    .clk(clk), .rst(rst), .start(start),
    .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
    .step_x(step_x), .step_y(step_y), .out_ready(out_ready),
    .out_valid(out_valid), .idx0(idx0), .idx1(idx1), .idx2(idx2),
    .idx3(idx3), .u(u), .u_sq(u_sq), .u_cu(u_cu), .src_y(src_y),
    .v(v), .line_last(line_last), .frame_done(frame_done), .busy(busy)
  );

  typedef struct packed {
    logic [11:0] i0, i1, i2, i3;
    logic [7:0]  u;
    logic [15:0] usq;
    logic [23:0] ucu;
    logic [11:0] sy;
    logic [7:0]  v;
    logic        ll;
  } samp_t;

  samp_t sb[$];
  samp_t log_q[$];
  samp_t got;
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int fd_cnt = 0;

  assign got = {idx0, idx1, idx2, idx3, u, u_sq, u_cu, src_y, v, line_last};

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int a, input int hi);
    if (a > hi) return hi;
    return a;
  endfunction

  function automatic samp_t model(input int x, input int y);
    samp_t s;
    longint px, py;
    int i, yi, wm, hm, uu;
    px = (longint'(x) * longint'(step_x)) % (64'd1 << 20);
    py = (longint'(y) * longint'(step_y)) % (64'd1 << 20);
    i  = int'(px / 256);
    yi = int'(py / 256);
    wm = int'(src_w) - 1;
    hm = int'(src_h) - 1;
    uu = int'(px % 256);
    s.i0  = 12'(clampi((i == 0) ? 0 : i - 1, wm));
    s.i1  = 12'(clampi(i, wm));
    s.i2  = 12'(clampi(i + 1, wm));
    s.i3  = 12'(clampi(i + 2, wm));
    s.u   = 8'(uu);
    s.usq = 16'(uu * uu);
    s.ucu = 24'(uu * uu * uu);
    s.sy  = 12'(clampi(yi, hm));
    s.v   = 8'(py % 256);
    s.ll  = (x == int'(dst_w) - 1);
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL extra_sample observed %0h expected none", got);
        end else begin
          chk("sample", got, sb[0]);
          if (out_ready) begin
            log_q.push_back(got);
            void'(sb.pop_front());
            acc_cnt++;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame;
    for (int y = 0; y < int'(dst_h); y++)
      for (int x = 0; x < int'(dst_w); x++)
        sb.push_back(model(x, y));
    log_q.delete();
    fd_cnt = 0;
    acc_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (fd_cnt == 0 && n < 600) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    chk("frame_done_count", fd_cnt, 1);
    chk("busy_after_done", busy, 0);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic wait_acc(input int k);
    int n = 0;
    while (acc_cnt < k && n < 100) begin
      tick();
      n++;
    end
    chk("accept_reached", acc_cnt >= k, 1);
  endtask

  task automatic cfg(input int sw, input int sh, input int dw, input int dh,
                     input int sx, input int sy);
    src_w  = 12'(sw);
    src_h  = 12'(sh);
    dst_w  = 12'(dw);
    dst_h  = 12'(dh);
    step_x = 20'(sx);
    step_y = 20'(sy);
  endtask

  task automatic check_f1_log(input string tag);
    int e_i1[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    chk({tag, "_len"}, log_q.size(), 8);
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      chk({tag, "_idx1"}, log_q[k].i1, e_i1[k]);
      chk({tag, "_u"}, log_q[k].u, (k % 2 == 1) ? 128 : 0);
      chk({tag, "_line_last"}, log_q[k].ll, (k == 7) ? 1 : 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    cfg(4, 4, 8, 1, 128, 256);
    tick();
    tick();
    chk("reset_outputs",
        {out_valid, idx0, idx1, idx2, idx3, u, u_sq, u_cu, src_y, v,
         line_last, frame_done, busy}, 0);
    rst = 1'b0;
    tick();

    // frame 1: 8x1 at half-pixel step, always ready; latency check
    start_frame();
    chk("busy_on_start", busy, 1);
    chk("latency_e0", out_valid, 0);
    tick();
    tick();
    chk("latency_e2", out_valid, 0);
    tick();
    chk("latency_e3", out_valid, 1);
    wait_done(0);
    check_f1_log("f1");
    if (log_q.size() == 8) begin
      chk("f1_usq", log_q[1].usq, 16384);
      chk("f1_ucu", log_q[1].ucu, 2097152);
      chk("f1_first_idx0", log_q[0].i0, 0);
      chk("f1_last_idx2", log_q[7].i2, 3);
      chk("f1_last_idx3", log_q[7].i3, 3);
    end

    // frame 2: same frame, 5-cycle stall after 3rd accept, start ignored
    start_frame();
    wait_acc(3);
    out_ready = 1'b0;
    dst_w = 12'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    dst_w = 12'd8;
    chk("stall_valid", out_valid, 1);
    repeat (4) tick();
    chk("stall_acc_frozen", acc_cnt, 3);
    out_ready = 1'b1;
    wait_done(0);
    check_f1_log("f2");

    // frame 3: 2x2, vertical half step
    cfg(4, 4, 2, 2, 256, 128);
    start_frame();
    wait_done(0);
    chk("f3_len", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("f3_l0_sy", log_q[0].sy, 0);
      chk("f3_l0_v", log_q[1].v, 0);
      chk("f3_l1_sy", log_q[2].sy, 0);
      chk("f3_l1_v", log_q[3].v, 128);
      chk("f3_idx1", log_q[3].i1, 1);
    end

    // frame 4: maximum fraction
    cfg(2, 1, 2, 1, 255, 0);
    start_frame();
    wait_done(0);
    if (log_q.size() == 2) begin
      chk("f4_u", log_q[1].u, 255);
      chk("f4_usq", log_q[1].usq, 65025);
      chk("f4_ucu", log_q[1].ucu, 16581375);
      chk("f4_idx1", log_q[1].i1, 0);
      chk("f4_idx2", log_q[1].i2, 1);
      chk("f4_idx3", log_q[1].i3, 1);
    end else chk("f4_len", log_q.size(), 2);

    // frame 5: empty frame
    cfg(4, 4, 0, 3, 256, 256);
    fd_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_frame_done", frame_done, 1);
    chk("zero_valid", out_valid, 0);
    tick();
    chk("zero_done_pulse", frame_done, 0);
    chk("zero_busy", busy, 0);
    chk("zero_fd_count", fd_cnt, 1);

    // frame 6: downscale with clamping under random backpressure
    cfg(5, 3, 7, 4, 200, 230);
    start_frame();
    wait_done(1);
    chk("f6_len", log_q.size(), 28);

    // reset mid-frame, then a fresh frame restarts at sample 0
    cfg(4, 4, 8, 1, 128, 256);
    start_frame();
    wait_acc(2);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_outputs",
        {out_valid, idx0, idx1, idx2, idx3, u, u_sq, u_cu, src_y, v,
         line_last, frame_done, busy}, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    tick();
    chk("midrst_idle_valid", out_valid, 0);
    start_frame();
    wait_done(0);
    check_f1_log("f7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bicubic_phase_gen.md
BICUBIC_PHASE_GEN -- requirements
Module: bicubic_phase_gen

Interface
REQ-001 The block SHALL have no parameters; all dimensions and steps SHALL be run-time inputs.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle frame request.
REQ-005 src_w, src_h  input  12 each  source frame width and height in pixels.
REQ-006 dst_w, dst_h  input  12 each  destination frame width and height in pixels.
REQ-007 step_x, step_y  input  20 each  source increment per destination pixel/line, unsigned 12.8 fixed point.
REQ-008 out_ready  input  1  downstream multiply-add stage accepts the current sample.
REQ-009 out_valid  output  1  sample fields valid.
REQ-010 idx0, idx1, idx2, idx3  output  12 each  clamped source column indices of the 4-tap window.
REQ-011 u  output  8  horizontal fraction, scale 2^8.
REQ-012 u_sq  output  16  u*u, exact.
REQ-013 u_cu  output  24  u*u*u, exact.
REQ-014 src_y  output  12  clamped source row index; v  output  8  vertical fraction.
REQ-015 line_last  output  1  current sample is the last sample of its destination line.
REQ-016 frame_done  output  1  one-cycle pulse after the last sample of the frame is accepted.
REQ-017 busy  output  1  high from start acceptance until frame_done inclusive.

Function
REQ-018 States: IDLE, RUN, DONE; start in IDLE SHALL latch all dimension/step inputs and enter RUN; start outside IDLE SHALL be ignored.
REQ-019 start with dst_w==0 or dst_h==0 SHALL enter DONE directly, produce no out_valid, and pulse frame_done on the following cycle.
REQ-020 In RUN, horizontal accumulator pos_x (20 bits) SHALL start at 0 and add step_x per issued sample; vertical accumulator pos_y SHALL start at 0 and add step_y at each line end, with pos_x reset to 0.
REQ-021 Counters x_cnt 0..dst_w-1 and y_cnt 0..dst_h-1 SHALL count issued samples; line_last SHALL mark x_cnt==dst_w-1.
REQ-022 With i=pos_x[19:8]: idx1=min(i,src_w-1), idx0=max(i-1,0) and clamped to src_w-1, idx2=min(i+1,src_w-1), idx3=min(i+2,src_w-1).
REQ-023 u=pos_x[7:0]; src_y=min(pos_y[19:8],src_h-1); v=pos_y[7:0].
REQ-024 Pipeline SHALL be 3 register stages (accumulate, square/clamp, cube) producing all fields of one sample coherently on the same cycle.
REQ-025 The whole pipeline SHALL advance only when out_valid==0 or out_ready==1; while stalled all outputs SHALL hold stable.
REQ-026 With out_ready held 1, the first out_valid SHALL assert on the 3rd rising edge after the edge that samples start, and samples SHALL follow at 1 per clock.
REQ-027 Exactly dst_w*dst_h samples SHALL be emitted per frame, in raster order, with no duplication or loss under any out_ready pattern.
REQ-028 After the last sample is accepted the block SHALL enter DONE, pulse frame_done for one cycle, deassert busy on the next cycle, and return to IDLE.
REQ-029 Accumulators SHALL not wrap within a frame for step*dst <= 2^20; overflow beyond that is outside scope and SHALL be masked by index clamping.

Reset
REQ-030 rst SHALL, on the next edge, force IDLE, clear accumulators, counters and pipeline, and drive every output to 0, including mid-frame.
REQ-031 Outputs SHALL be 0 after rst until a new start is accepted.

Verification
REQ-032 src_w=4, dst_w=8, dst_h=1, step_x=128, ready=1 -> (idx1,u) = (0,0),(0,128),(1,0),(1,128),(2,0),(2,128),(3,0),(3,128); u=128 gives u_sq=16384, u_cu=2097152; first idx0=0; last idx2=idx3=3; line_last only on 8th sample; one frame_done.
REQ-033 Same frame, out_ready low for 5 cycles after 3rd sample -> sample 3 held unchanged during stall, then sequence continues from sample 4 with no gap in indices.
REQ-034 dst_w=2, dst_h=2, step_x=256, step_y=128, src_h=4 -> line 0 src_y=0 v=0, line 1 src_y=0 v=128; frame_done once after 4th accept.
REQ-035 step_x=255, src_w=2, dst_w=2 -> 2nd sample u=255, u_sq=65025, u_cu=16581375, idx1=0, idx2=1, idx3=1.
REQ-036 dst_w=0 -> no out_valid, frame_done pulse one cycle after start; start during busy ignored; rst mid-frame -> all outputs 0 next cycle, fresh start restarts at sample 0.
